// File: rtl/exc_csr_seq.sv
// Exception/ertn CSR sequencer: serialises exception entry and ertn CSR updates
// over one shared CSR port and passes ordinary CSR instructions straight through.
module exc_csr_seq (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_valid,
   input  logic        wb_ex,
   input  logic        wb_ertn,
   input  logic [14:0] wb_excode,
   input  logic [31:0] wb_pc,
   input  logic        wb_badv_valid,
   input  logic [31:0] wb_badv,
   input  logic        wb_csr_re,
   input  logic        wb_csr_we,
   input  logic [13:0] wb_csr_num,
   input  logic [31:0] wb_csr_wmask,
   input  logic [31:0] wb_csr_wvalue,
   output logic [31:0] wb_csr_rdata,
   output logic        wb_stall,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic        csr_re,
   output logic [13:0] csr_num,
   input  logic [31:0] csr_rvalue,
   output logic        csr_we,
   output logic [31:0] csr_wmask,
   output logic [31:0] csr_wvalue
);

   localparam logic [13:0] CSR_CRMD   = 14'h0;
   localparam logic [13:0] CSR_PRMD   = 14'h1;
   localparam logic [13:0] CSR_ESTAT  = 14'h5;
   localparam logic [13:0] CSR_ERA    = 14'h6;
   localparam logic [13:0] CSR_BADV   = 14'h7;
   localparam logic [13:0] CSR_EENTRY = 14'hC;

   typedef enum logic [3:0] {
      IDLE,
      EX_WPRMD,
      EX_WCRMD,
      EX_WESTAT,
      EX_WERA,
      EX_WBADV,
      EX_REENTRY,
      ER_WCRMD,
      ER_RERA
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] tmp_q, tmp_d;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         tmp_q   <= 3'b0;
      end else begin
         state_q <= state_d;
         tmp_q   <= tmp_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      tmp_d        = tmp_q;
      wb_csr_rdata = 32'b0;
      wb_stall     = 1'b0;
      flush        = 1'b0;
      redirect_pc  = 32'b0;
      csr_re       = 1'b0;
      csr_we       = 1'b0;
      csr_num      = 14'b0;
      csr_wmask    = 32'b0;
      csr_wvalue   = 32'b0;

      case (state_q)
         IDLE: begin
            // Exception wins over ertn; the instruction's own CSR request is dropped.
            if (wb_valid && wb_ex) begin
               csr_re   = 1'b1;
               csr_num  = CSR_CRMD;
               tmp_d    = csr_rvalue[2:0];
               wb_stall = 1'b1;
               state_d  = EX_WPRMD;
            end else if (wb_valid && wb_ertn) begin
               csr_re   = 1'b1;
               csr_num  = CSR_PRMD;
               tmp_d    = csr_rvalue[2:0];
               wb_stall = 1'b1;
               state_d  = ER_WCRMD;
            end else if (wb_valid) begin
               csr_re       = wb_csr_re;
               csr_we       = wb_csr_we;
               csr_num      = wb_csr_num;
               csr_wmask    = wb_csr_wmask;
               csr_wvalue   = wb_csr_wvalue;
               wb_csr_rdata = csr_rvalue;
            end
         end
         EX_WPRMD: begin
            csr_we     = 1'b1;
            csr_num    = CSR_PRMD;
            csr_wmask  = 32'h7;
            csr_wvalue = {29'b0, tmp_q};
            wb_stall   = 1'b1;
            state_d    = EX_WCRMD;
         end
         EX_WCRMD: begin
            csr_we     = 1'b1;
            csr_num    = CSR_CRMD;
            csr_wmask  = 32'h7;
            csr_wvalue = 32'b0;
            wb_stall   = 1'b1;
            state_d    = EX_WESTAT;
         end
         EX_WESTAT: begin
            csr_we     = 1'b1;
            csr_num    = CSR_ESTAT;
            csr_wmask  = 32'h7FFF_0000;
            csr_wvalue = {1'b0, wb_excode, 16'b0};
            wb_stall   = 1'b1;
            state_d    = EX_WERA;
         end
         EX_WERA: begin
            csr_we     = 1'b1;
            csr_num    = CSR_ERA;
            csr_wmask  = 32'hFFFF_FFFF;
            csr_wvalue = wb_pc;
            wb_stall   = 1'b1;
            state_d    = wb_badv_valid ? EX_WBADV : EX_REENTRY;
         end
         EX_WBADV: begin
            csr_we     = 1'b1;
            csr_num    = CSR_BADV;
            csr_wmask  = 32'hFFFF_FFFF;
            csr_wvalue = wb_badv;
            wb_stall   = 1'b1;
            state_d    = EX_REENTRY;
         end
         EX_REENTRY: begin
            csr_re      = 1'b1;
            csr_num     = CSR_EENTRY;
            flush       = 1'b1;
            redirect_pc = csr_rvalue;
            state_d     = IDLE;
         end
         ER_WCRMD: begin
            csr_we     = 1'b1;
            csr_num    = CSR_CRMD;
            csr_wmask  = 32'h7;
            csr_wvalue = {29'b0, tmp_q};
            wb_stall   = 1'b1;
            state_d    = ER_RERA;
         end
         ER_RERA: begin
            csr_re      = 1'b1;
            csr_num     = CSR_ERA;
            flush       = 1'b1;
            redirect_pc = csr_rvalue;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Reset silences the CSR port immediately so an aborted sequence writes nothing more.
      if (!resetn) begin
         state_d      = IDLE;
         tmp_d        = 3'b0;
         wb_csr_rdata = 32'b0;
         wb_stall     = 1'b0;
         flush        = 1'b0;
         redirect_pc  = 32'b0;
         csr_re       = 1'b0;
         csr_we       = 1'b0;
         csr_num      = 14'b0;
         csr_wmask    = 32'b0;
         csr_wvalue   = 32'b0;
      end
   end

endmodule

// File: tb/tb_exc_csr_seq.sv
// Bench for exc_csr_seq: a small CSR file model, a table of single-cycle
// pass-through vectors, and directed exception / ertn / reset sequences.
module tb_exc_csr_seq;

   logic        clk = 1'b0;
   logic        resetn;
   logic        wb_valid, wb_ex, wb_ertn, wb_badv_valid;
   logic [14:0] wb_excode;
   logic [31:0] wb_pc, wb_badv;
   logic        wb_csr_re, wb_csr_we;
   logic [13:0] wb_csr_num;
   logic [31:0] wb_csr_wmask, wb_csr_wvalue;
   logic [31:0] wb_csr_rdata;
   logic        wb_stall, flush;
   logic [31:0] redirect_pc;
   logic        csr_re, csr_we;
   logic [13:0] csr_num;
   logic [31:0] csr_rvalue, csr_wmask, csr_wvalue;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   exc_csr_seq dut (
      .clk(clk), .resetn(resetn),
      .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_ertn(wb_ertn),
      .wb_excode(wb_excode), .wb_pc(wb_pc),
      .wb_badv_valid(wb_badv_valid), .wb_badv(wb_badv),
      .wb_csr_re(wb_csr_re), .wb_csr_we(wb_csr_we), .wb_csr_num(wb_csr_num),
      .wb_csr_wmask(wb_csr_wmask), .wb_csr_wvalue(wb_csr_wvalue),
      .wb_csr_rdata(wb_csr_rdata), .wb_stall(wb_stall), .flush(flush),
      .redirect_pc(redirect_pc), .csr_re(csr_re), .csr_num(csr_num),
      .csr_rvalue(csr_rvalue), .csr_we(csr_we),
      .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue)
   );

   // CSR file model: combinational read, masked write at posedge, bench-side poke port.
   logic [31:0] csr_mem [0:15];
   logic        poke_en = 1'b0;
   logic [3:0]  poke_idx = 4'd0;
   logic [31:0] poke_val = 32'd0;

   assign csr_rvalue = (csr_num < 14'd16) ? csr_mem[csr_num[3:0]] : 32'd0;

   always @(posedge clk) begin
      if (poke_en)
         csr_mem[poke_idx] <= poke_val;
      else if (csr_we && csr_num < 14'd16)
         csr_mem[csr_num[3:0]] <= (csr_mem[csr_num[3:0]] & ~csr_wmask) | (csr_wvalue & csr_wmask);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic poke(input logic [3:0] idx, input logic [31:0] val);
      poke_en  = 1'b1;
      poke_idx = idx;
      poke_val = val;
      @(posedge clk);
      #1 poke_en = 1'b0;
   endtask

   task automatic clear_wb();
      wb_valid = 0; wb_ex = 0; wb_ertn = 0; wb_excode = '0; wb_pc = '0;
      wb_badv_valid = 0; wb_badv = '0; wb_csr_re = 0; wb_csr_we = 0;
      wb_csr_num = '0; wb_csr_wmask = '0; wb_csr_wvalue = '0;
   endtask

   // Inputs are already driven for cycle 0; watches stall until the flush cycle.
   task automatic run_seq(input string name, input int max_cyc,
                          output int fidx, output logic [31:0] rpc);
      int nfl = 0;
      fidx = -1;
      rpc  = '0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (flush) begin
            nfl++;
            fidx = c;
            rpc  = redirect_pc;
            check({name, " stall in flush cycle"}, {31'b0, wb_stall}, 32'd0);
            @(posedge clk);
            #1 clear_wb();
            break;
         end
         check({name, " stall before flush"}, {31'b0, wb_stall}, 32'd1);
         @(posedge clk);
         #1;
      end
      if (fidx < 0) begin
         check({name, " flush timeout"}, 32'd0, 32'd1);
         clear_wb();
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (flush) nfl++;
      end
      check({name, " flush count"}, nfl, 32'd1);
   endtask

   typedef struct {
      logic        valid, re, we;
      logic [13:0] num;
      logic [31:0] mask, val;
      logic        e_re, e_we;
      logic [13:0] e_num;
      logic [31:0] e_mask, e_val, e_rdata;
      logic        e_stall;
   } vec_t;

   vec_t vt [7];
   int          fidx;
   logic [31:0] rpc;

   initial begin
      vt[0] = '{1'b0, 1'b1, 1'b1, 14'h6, 32'hFFFF_FFFF, 32'h1234,
                1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h0, 1'b0};
      vt[1] = '{1'b1, 1'b1, 1'b1, 14'h6, 32'hFFFF_FFFF, 32'h1234,
                1'b1, 1'b1, 14'h6, 32'hFFFF_FFFF, 32'h1234, 32'h0, 1'b0};
      vt[2] = '{1'b1, 1'b1, 1'b0, 14'h6, 32'h0, 32'h0,
                1'b1, 1'b0, 14'h6, 32'h0, 32'h0, 32'h1234, 1'b0};
      vt[3] = '{1'b1, 1'b1, 1'b1, 14'h0, 32'h3, 32'h5,
                1'b1, 1'b1, 14'h0, 32'h3, 32'h5, 32'h7, 1'b0};
      vt[4] = '{1'b1, 1'b1, 1'b0, 14'h0, 32'h0, 32'h0,
                1'b1, 1'b0, 14'h0, 32'h0, 32'h0, 32'h5, 1'b0};
      vt[5] = '{1'b1, 1'b0, 1'b0, 14'hC, 32'h0, 32'h0,
                1'b0, 1'b0, 14'hC, 32'h0, 32'h0, 32'h1C00_8000, 1'b0};
      vt[6] = '{1'b1, 1'b1, 1'b1, 14'h0, 32'h7, 32'h7,
                1'b1, 1'b1, 14'h0, 32'h7, 32'h7, 32'h5, 1'b0};

      clear_wb();
      resetn = 1'b0;
      @(posedge clk);
      #1;
      wb_valid = 1; wb_csr_re = 1; wb_csr_we = 1; wb_csr_num = 14'h6;
      wb_csr_wmask = 32'hFFFF_FFFF; wb_csr_wvalue = 32'h99;
      @(negedge clk);
      check("reset csr_we", {31'b0, csr_we}, 32'd0);
      check("reset csr_re", {31'b0, csr_re}, 32'd0);
      check("reset wb_csr_rdata", wb_csr_rdata, 32'd0);
      check("reset stall/flush", {30'b0, wb_stall, flush}, 32'd0);
      @(posedge clk);
      #1 clear_wb();

      poke(4'h0, 32'h7);
      poke(4'h1, 32'h0);
      poke(4'h5, 32'h0);
      poke(4'h6, 32'h0);
      poke(4'h7, 32'h0);
      poke(4'hC, 32'h1C00_8000);
      resetn = 1'b1;

      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         #1;
         wb_valid = vt[i].valid; wb_csr_re = vt[i].re; wb_csr_we = vt[i].we;
         wb_csr_num = vt[i].num; wb_csr_wmask = vt[i].mask; wb_csr_wvalue = vt[i].val;
         @(negedge clk);
         check($sformatf("vec%0d csr_re", i), {31'b0, csr_re}, {31'b0, vt[i].e_re});
         check($sformatf("vec%0d csr_we", i), {31'b0, csr_we}, {31'b0, vt[i].e_we});
         check($sformatf("vec%0d csr_num", i), {18'b0, csr_num}, {18'b0, vt[i].e_num});
         check($sformatf("vec%0d csr_wmask", i), csr_wmask, vt[i].e_mask);
         check($sformatf("vec%0d csr_wvalue", i), csr_wvalue, vt[i].e_val);
         check($sformatf("vec%0d wb_csr_rdata", i), wb_csr_rdata, vt[i].e_rdata);
         check($sformatf("vec%0d stall", i), {31'b0, wb_stall}, {31'b0, vt[i].e_stall});
         check($sformatf("vec%0d flush", i), {31'b0, flush}, 32'd0);
      end
      @(posedge clk);
      #1 clear_wb();
      check("ERA after csrwr", csr_mem[6], 32'h1234);

      // Exception without bad vaddr: flush five cycles after entry.
      @(posedge clk);
      #1;
      wb_valid = 1; wb_ex = 1; wb_excode = 15'h000B; wb_pc = 32'h1C00_0100;
      run_seq("ex1", 12, fidx, rpc);
      check("ex1 flush cycle", fidx, 32'd5);
      check("ex1 redirect", rpc, 32'h1C00_8000);
      check("ex1 PRMD", csr_mem[1], 32'h7);
      check("ex1 CRMD", csr_mem[0], 32'h0);
      check("ex1 ESTAT", csr_mem[5], 32'h000B_0000);
      check("ex1 ERA", csr_mem[6], 32'h1C00_0100);
      check("ex1 BADV", csr_mem[7], 32'h0);

      // Exception with bad vaddr; ESTAT low bits must survive the masked write.
      poke(4'h0, 32'h3);
      poke(4'h5, 32'h3);
      wb_valid = 1; wb_ex = 1; wb_excode = {9'h1, 6'h08}; wb_pc = 32'h1C00_0180;
      wb_badv_valid = 1; wb_badv = 32'hDEAD_BEEF;
      run_seq("ex2", 12, fidx, rpc);
      check("ex2 flush cycle", fidx, 32'd6);
      check("ex2 redirect", rpc, 32'h1C00_8000);
      check("ex2 BADV", csr_mem[7], 32'hDEAD_BEEF);
      check("ex2 PRMD", csr_mem[1], 32'h3);
      check("ex2 ESTAT", csr_mem[5], 32'h0048_0003);
      check("ex2 ERA", csr_mem[6], 32'h1C00_0180);

      // ertn restores CRMD[2:0] from PRMD and leaves upper CRMD bits alone.
      poke(4'h1, 32'h5);
      poke(4'h6, 32'h1C00_0200);
      poke(4'h0, 32'hF8);
      wb_valid = 1; wb_ertn = 1;
      run_seq("ertn", 8, fidx, rpc);
      check("ertn flush cycle", fidx, 32'd2);
      check("ertn redirect", rpc, 32'h1C00_0200);
      check("ertn CRMD", csr_mem[0], 32'hFD);

      // ex + ertn + instruction write: only the exception sequence runs.
      poke(4'h0, 32'h2);
      poke(4'h7, 32'h1111_1111);
      wb_valid = 1; wb_ex = 1; wb_ertn = 1; wb_excode = 15'h0001; wb_pc = 32'h1C00_0300;
      wb_csr_re = 1; wb_csr_we = 1; wb_csr_num = 14'h7;
      wb_csr_wmask = 32'hFFFF_FFFF; wb_csr_wvalue = 32'h5555_5555;
      run_seq("combo", 12, fidx, rpc);
      check("combo flush cycle", fidx, 32'd5);
      check("combo redirect", rpc, 32'h1C00_8000);
      check("combo BADV untouched", csr_mem[7], 32'h1111_1111);
      check("combo ERA", csr_mem[6], 32'h1C00_0300);
      check("combo PRMD", csr_mem[1], 32'h2);

      // Reset while in EX_WERA aborts the sequence before ERA is written.
      poke(4'h6, 32'hAAAA_0000);
      poke(4'h5, 32'h0);
      wb_valid = 1; wb_ex = 1; wb_excode = 15'h0002; wb_pc = 32'h1C00_0400;
      repeat (4) @(posedge clk);
      #1 resetn = 1'b0;
      @(negedge clk);
      check("rst mid csr_we", {31'b0, csr_we}, 32'd0);
      check("rst mid flush", {31'b0, flush}, 32'd0);
      check("rst mid stall", {31'b0, wb_stall}, 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      clear_wb();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("post-rst outputs c%0d", c),
               {29'b0, flush, wb_stall, csr_we}, 32'd0);
      end
      check("rst ESTAT progressed", csr_mem[5], 32'h0002_0000);
      check("rst ERA untouched", csr_mem[6], 32'hAAAA_0000);

      // Sequencer must be back in IDLE and pass a CSR instruction straight through.
      @(posedge clk);
      #1;
      wb_valid = 1; wb_csr_re = 1; wb_csr_num = 14'h6;
      @(negedge clk);
      check("post-rst rdata", wb_csr_rdata, 32'hAAAA_0000);
      check("post-rst stall", {31'b0, wb_stall}, 32'd0);
      @(posedge clk);
      #1 clear_wb();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
